// File: rtl/vga_rect_filler.sv
// Raster-order rectangle fill engine driving the vga_adapter pixel-write port.
// Define RECT_CLIP_EN to suppress plotting of pixels outside SCREEN_W x SCREEN_H.
module vga_rect_filler #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clock_i,
    input  logic                resetn_i,
    input  logic                start_i,
    input  logic [X_W-1:0]      x0_i,
    input  logic [Y_W-1:0]      y0_i,
    input  logic [X_W-1:0]      w_i,
    input  logic [Y_W-1:0]      h_i,
    input  logic [COLOUR_W-1:0] colour_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [X_W-1:0]      x_o,
    output logic [Y_W-1:0]      y_o,
    output logic [COLOUR_W-1:0] colour_o,
    output logic                plot_o
);

    typedef enum logic {
        IDLE,
        DRAW
    } state_e;

    state_e              state_q;
    logic [X_W-1:0]      x0_q, w_q, col_q;
    logic [Y_W-1:0]      y0_q, h_q, row_q;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q, busy_q, done_q;

    logic [X_W-1:0]      baseX, col_d, pixX;
    logic [Y_W-1:0]      baseY, row_d, pixY;
    logic                lastCol, lastPixel, onScreen;

    // In IDLE the pixel being prepared is the first one of the incoming command,
    // so the origin comes straight from the inputs; in DRAW it is the successor pixel.
    always_comb begin
        baseX     = x0_q;
        baseY     = y0_q;
        col_d     = col_q;
        row_d     = row_q;
        lastCol   = 1'b0;
        lastPixel = 1'b0;
        if (state_q == IDLE) begin
            baseX = x0_i;
            baseY = y0_i;
            col_d = '0;
            row_d = '0;
        end else begin
            lastCol = (col_q == w_q - X_W'(1));
            if (lastCol) begin
                col_d = '0;
                row_d = row_q + Y_W'(1);
            end else begin
                col_d = col_q + X_W'(1);
            end
            lastPixel = lastCol && (row_q == h_q - Y_W'(1));
        end
    end

`ifdef RECT_CLIP_EN
    logic [X_W:0] sumX;
    logic [Y_W:0] sumY;

    assign sumX     = {1'b0, baseX} + {1'b0, col_d};
    assign sumY     = {1'b0, baseY} + {1'b0, row_d};
    assign pixX     = sumX[X_W-1:0];
    assign pixY     = sumY[Y_W-1:0];
    assign onScreen = (sumX < (X_W+1)'(SCREEN_W)) && (sumY < (Y_W+1)'(SCREEN_H));
`else
    assign pixX     = baseX + col_d;
    assign pixY     = baseY + row_d;
    assign onScreen = 1'b1;
`endif

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        x0_q  <= x0_i;
                        y0_q  <= y0_i;
                        w_q   <= w_i;
                        h_q   <= h_i;
                        col_q <= '0;
                        row_q <= '0;
                        // An empty rectangle completes immediately without touching the pixel port.
                        if ((w_i != '0) && (h_i != '0)) begin
                            state_q  <= DRAW;
                            busy_q   <= 1'b1;
                            plot_q   <= onScreen;
                            x_q      <= pixX;
                            y_q      <= pixY;
                            colour_q <= colour_i;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (lastPixel) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        col_q  <= col_d;
                        row_q  <= row_d;
                        plot_q <= onScreen;
                        x_q    <= pixX;
                        y_q    <= pixY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign colour_o = colour_q;
    assign plot_o   = plot_q;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Self-checking bench for vga_rect_filler; expected pixel streams come from a raster-order model.
// Honours RECT_CLIP_EN the same way as the design.
module tb_vga_rect_filler;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x0 = '0;
    logic [6:0] y0 = '0;
    logic [7:0] w = '0;
    logic [6:0] h = '0;
    logic [2:0] colourIn = '0;
    logic       busy, done, plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       busy;
        logic       done;
        logic       chk;
    } exp_t;

    exp_t expQ[$];

    vga_rect_filler dut (
        .clock_i (clock),
        .resetn_i(resetn),
        .start_i (start),
        .x0_i    (x0),
        .y0_i    (y0),
        .w_i     (w),
        .h_i     (h),
        .colour_i(colourIn),
        .busy_o  (busy),
        .done_o  (done),
        .x_o     (x),
        .y_o     (y),
        .colour_o(colour),
        .plot_o  (plot)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launches a command sampled at the next edge; returns at the first-pixel cycle.
    task automatic issue(input int ax, input int ay, input int aw, input int ah, input int ac);
        x0       = 8'(ax);
        y0       = 7'(ay);
        w        = 8'(aw);
        h        = 7'(ah);
        colourIn = 3'(ac);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Per-cycle expectation from the first-pixel cycle on: w*h pixels in raster
    // order, one done cycle, then optionally one quiet cycle.
    function automatic void buildExpected(input int bx, input int by, input int bw, input int bh,
                                          input int bc, input bit withTail);
        exp_t e;
        expQ.delete();
        for (int r = 0; r < bh; r++) begin
            for (int c = 0; c < bw; c++) begin
                int sx = bx + c;
                int sy = by + r;
`ifdef RECT_CLIP_EN
                e.plot = (sx < 160) && (sy < 120);
`else
                e.plot = 1'b1;
`endif
                e.x    = sx[7:0];
                e.y    = sy[6:0];
                e.c    = 3'(bc);
                e.busy = 1'b1;
                e.done = 1'b0;
                e.chk  = 1'b1;
                expQ.push_back(e);
            end
        end
        e = '{plot: 1'b0, x: '0, y: '0, c: '0, busy: 1'b0, done: 1'b1, chk: 1'b0};
        expQ.push_back(e);
        if (withTail) begin
            e.done = 1'b0;
            expQ.push_back(e);
        end
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checkCount++;
        if ({x, y, colour, plot, busy, done} !== 21'd0)
            $display("[TB] FAIL reset_state: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, want all 0",
                     x, y, colour, plot, busy, done);
        else passCount++;
        resetn = 1'b1;
        tick();
        checkCount++;
        if ({plot, busy, done} !== 3'b000)
            $display("[TB] FAIL reset_release_idle: got plot=%b busy=%b done=%b, want 000", plot, busy, done);
        else passCount++;
    endtask

    task automatic test_basic();
        issue(10, 20, 2, 2, 5);
        buildExpected(10, 20, 2, 2, 5, 1'b1);
        for (int k = 0; k < expQ.size(); k++) begin
            checkCount++;
            if ({plot, busy, done} !== {expQ[k].plot, expQ[k].busy, expQ[k].done} ||
                (expQ[k].chk && ({x, y, colour} !== {expQ[k].x, expQ[k].y, expQ[k].c})))
                $display("[TB] FAIL basic step %0d: got p=%b b=%b d=%b x=%0d y=%0d c=%0d, want p=%b b=%b d=%b x=%0d y=%0d c=%0d",
                         k, plot, busy, done, x, y, colour, expQ[k].plot, expQ[k].busy, expQ[k].done,
                         expQ[k].x, expQ[k].y, expQ[k].c);
            else passCount++;
            tick();
        end
    endtask

    task automatic test_empty();
        int ws[2] = '{0, 3};
        int hs[2] = '{7, 0};
        for (int i = 0; i < 2; i++) begin
            issue(20, 30, ws[i], hs[i], 4);
            checkCount++;
            if ({plot, busy, done} !== 3'b001)
                $display("[TB] FAIL empty_done w=%0d h=%0d: got plot=%b busy=%b done=%b, want 001",
                         ws[i], hs[i], plot, busy, done);
            else passCount++;
            for (int t = 0; t < 3; t++) begin
                tick();
                checkCount++;
                if ({plot, busy, done} !== 3'b000)
                    $display("[TB] FAIL empty_after w=%0d h=%0d t=%0d: got plot=%b busy=%b done=%b, want 000",
                             ws[i], hs[i], t, plot, busy, done);
                else passCount++;
            end
        end
    endtask

    task automatic test_ignore_start();
        issue(40, 50, 4, 1, 3);
        buildExpected(40, 50, 4, 1, 3, 1'b1);
        for (int k = 0; k < expQ.size(); k++) begin
            checkCount++;
            if ({plot, busy, done} !== {expQ[k].plot, expQ[k].busy, expQ[k].done} ||
                (expQ[k].chk && ({x, y, colour} !== {expQ[k].x, expQ[k].y, expQ[k].c})))
                $display("[TB] FAIL ignore_start step %0d: got p=%b b=%b d=%b x=%0d y=%0d c=%0d, want p=%b b=%b d=%b x=%0d y=%0d c=%0d",
                         k, plot, busy, done, x, y, colour, expQ[k].plot, expQ[k].busy, expQ[k].done,
                         expQ[k].x, expQ[k].y, expQ[k].c);
            else passCount++;
            if (k == 1) begin
                x0       = 8'd99;
                y0       = 7'd9;
                w        = 8'd7;
                h        = 7'd3;
                colourIn = 3'd6;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        issue(1, 2, 3, 1, 2);
        buildExpected(1, 2, 3, 1, 2, 1'b0);
        for (int k = 0; k < expQ.size(); k++) begin
            checkCount++;
            if ({plot, busy, done} !== {expQ[k].plot, expQ[k].busy, expQ[k].done} ||
                (expQ[k].chk && ({x, y, colour} !== {expQ[k].x, expQ[k].y, expQ[k].c})))
                $display("[TB] FAIL b2b_first step %0d: got p=%b b=%b d=%b x=%0d y=%0d c=%0d, want p=%b b=%b d=%b x=%0d y=%0d c=%0d",
                         k, plot, busy, done, x, y, colour, expQ[k].plot, expQ[k].busy, expQ[k].done,
                         expQ[k].x, expQ[k].y, expQ[k].c);
            else passCount++;
            if (k == expQ.size() - 1) begin
                x0       = 8'd70;
                y0       = 7'd80;
                w        = 8'd2;
                h        = 7'd2;
                colourIn = 3'd7;
                start    = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        buildExpected(70, 80, 2, 2, 7, 1'b1);
        for (int k = 0; k < expQ.size(); k++) begin
            checkCount++;
            if ({plot, busy, done} !== {expQ[k].plot, expQ[k].busy, expQ[k].done} ||
                (expQ[k].chk && ({x, y, colour} !== {expQ[k].x, expQ[k].y, expQ[k].c})))
                $display("[TB] FAIL b2b_second step %0d: got p=%b b=%b d=%b x=%0d y=%0d c=%0d, want p=%b b=%b d=%b x=%0d y=%0d c=%0d",
                         k, plot, busy, done, x, y, colour, expQ[k].plot, expQ[k].busy, expQ[k].done,
                         expQ[k].x, expQ[k].y, expQ[k].c);
            else passCount++;
            tick();
        end
    endtask

    task automatic test_boundary();
        int bx[3] = '{158, 254, 5};
        int by[3] = '{0, 10, 126};
        int bw[3] = '{4, 4, 1};
        int bh[3] = '{1, 1, 3};
        for (int i = 0; i < 3; i++) begin
            issue(bx[i], by[i], bw[i], bh[i], i + 1);
            buildExpected(bx[i], by[i], bw[i], bh[i], i + 1, 1'b1);
            for (int k = 0; k < expQ.size(); k++) begin
                checkCount++;
                if ({plot, busy, done} !== {expQ[k].plot, expQ[k].busy, expQ[k].done} ||
                    (expQ[k].chk && ({x, y, colour} !== {expQ[k].x, expQ[k].y, expQ[k].c})))
                    $display("[TB] FAIL boundary case %0d step %0d: got p=%b b=%b d=%b x=%0d y=%0d c=%0d, want p=%b b=%b d=%b x=%0d y=%0d c=%0d",
                             i, k, plot, busy, done, x, y, colour, expQ[k].plot, expQ[k].busy, expQ[k].done,
                             expQ[k].x, expQ[k].y, expQ[k].c);
                else passCount++;
                tick();
            end
        end
    endtask

    task automatic test_reset_middraw();
        int  plots   = 0;
        bit  seenDone = 1'b0;
        issue(3, 4, 3, 3, 6);
        for (int k = 0; k < 3; k++) begin
            checkCount++;
            if ({plot, x, y} !== {1'b1, 8'(3 + k), 7'd4})
                $display("[TB] FAIL middraw_pixel %0d: got plot=%b x=%0d y=%0d, want plot=1 x=%0d y=4",
                         k, plot, x, y, 3 + k);
            else passCount++;
            tick();
        end
        resetn = 1'b0;
        for (int t = 0; t < 2; t++) begin
            tick();
            checkCount++;
            if ({x, y, colour, plot, busy, done} !== 21'd0)
                $display("[TB] FAIL middraw_reset t=%0d: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, want all 0",
                         t, x, y, colour, plot, busy, done);
            else passCount++;
        end
        resetn = 1'b1;
        tick();
        checkCount++;
        if ({plot, busy, done} !== 3'b000)
            $display("[TB] FAIL middraw_release: got plot=%b busy=%b done=%b, want 000", plot, busy, done);
        else passCount++;
        issue(50, 60, 2, 2, 1);
        checkCount++;
        if ({plot, x, y, colour} !== {1'b1, 8'd50, 7'd60, 3'd1})
            $display("[TB] FAIL restart_origin: got plot=%b x=%0d y=%0d c=%0d, want plot=1 x=50 y=60 c=1",
                     plot, x, y, colour);
        else passCount++;
        for (int t = 0; t < 20 && !seenDone; t++) begin
            if (plot) plots++;
            if (done) seenDone = 1'b1;
            else tick();
        end
        checkCount++;
        if (!seenDone || plots != 4)
            $display("[TB] FAIL restart_count: got done_seen=%0d plots=%0d, want done_seen=1 plots=4",
                     seenDone, plots);
        else passCount++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int ax = int'($urandom_range(0, 255));
            int ay = int'($urandom_range(0, 127));
            int aw = int'($urandom_range(0, 6));
            int ah = int'($urandom_range(0, 5));
            int ac = int'($urandom_range(0, 7));
            issue(ax, ay, aw, ah, ac);
            buildExpected(ax, ay, aw, ah, ac, 1'b1);
            for (int k = 0; k < expQ.size(); k++) begin
                checkCount++;
                if ({plot, busy, done} !== {expQ[k].plot, expQ[k].busy, expQ[k].done} ||
                    (expQ[k].chk && ({x, y, colour} !== {expQ[k].x, expQ[k].y, expQ[k].c})))
                    $display("[TB] FAIL random cmd %0d step %0d: got p=%b b=%b d=%b x=%0d y=%0d c=%0d, want p=%b b=%b d=%b x=%0d y=%0d c=%0d",
                             i, k, plot, busy, done, x, y, colour, expQ[k].plot, expQ[k].busy, expQ[k].done,
                             expQ[k].x, expQ[k].y, expQ[k].c);
                else passCount++;
                x0       = 8'($urandom);
                y0       = 7'($urandom);
                w        = 8'($urandom);
                h        = 7'($urandom);
                colourIn = 3'($urandom);
                tick();
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_empty();
        test_ignore_start();
        test_back_to_back();
        test_boundary();
        test_reset_middraw();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want completion", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
